led_red_pwm_driver: RTL and testbench



---
 rtl/led_red_pwm_driver.sv | 171 +++++++++++++++++
 tb/tb_led_red_pwm_driver.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_red_pwm_driver.sv
// Red-LED PIO output stage: frame-synchronous brightness PWM and per-LED blink behind a 4-word Avalon-MM slave.
// Defining LED_BREATHE_EN builds the optional triangle-ramp "breathe" brightness mode (CTRL[9]).
module led_red_pwm_driver #(
    parameter int WIDTH     = 18,
    parameter int PRESC_DIV = 196,
    parameter int BLINK_RST = 500
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] led_pattern,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] led_out
);
    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC_DIV - 1);

    typedef enum logic [1:0] {
        ADDR_CTRL   = 2'd0,
        ADDR_MASK   = 2'd1,
        ADDR_HALF   = 2'd2,
        ADDR_STATUS = 2'd3
    } addr_e;

    logic [PW-1:0]    presc;
    logic [7:0]       pwm_cnt;
    logic             step;
    logic             frame;
    logic             wr;

    logic [7:0]       duty;
    logic             enable;
    logic             breathe;
    logic [WIDTH-1:0] blink_mask;
    logic [15:0]      blink_half;

    logic [WIDTH-1:0] pat_sh;
    logic [WIDTH-1:0] mask_sh;
    logic [7:0]       duty_sh;
    logic [7:0]       duty_next;
    logic [15:0]      blink_cnt;
    logic [15:0]      half_eff;
    logic             blink_phase;
    logic             on;

    // Several writedata bits have no register behind them; fold them away explicitly.
    logic             unused_bits;
    assign unused_bits = ^writedata;

    assign wr       = chipselect && !write_n;
    assign step     = (presc == PRESC_MAX);
    assign frame    = step && (pwm_cnt == 8'hFF);
    assign half_eff = (blink_half == 16'd0) ? 16'd1 : blink_half;
    assign on       = (duty_sh == 8'hFF) || (pwm_cnt < duty_sh);

    // Host-visible registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            duty       <= 8'hFF;
            enable     <= 1'b1;
            blink_mask <= '0;
            blink_half <= 16'(BLINK_RST);
        end else if (wr) begin
            case (addr_e'(address))
                ADDR_CTRL: begin
                    duty   <= writedata[7:0];
                    enable <= writedata[8];
                end
                ADDR_MASK: blink_mask <= writedata[WIDTH-1:0];
                ADDR_HALF: blink_half <= writedata[15:0];
                ADDR_STATUS: ;
            endcase
        end
    end

`ifdef LED_BREATHE_EN
    logic [7:0] ramp;
    logic       ramp_down;

    // Ramp restarts from 0/up whenever breathe is switched on.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            breathe   <= 1'b0;
            ramp      <= 8'd0;
            ramp_down <= 1'b0;
        end else begin
            if (wr && address == ADDR_CTRL)
                breathe <= writedata[9];
            if (wr && address == ADDR_CTRL && writedata[9] && !breathe) begin
                ramp      <= 8'd0;
                ramp_down <= 1'b0;
            end else if (frame && breathe) begin
                if (!ramp_down) begin
                    if (ramp < duty) begin
                        ramp <= ramp + 8'd1;
                    end else begin
                        ramp_down <= 1'b1;
                        ramp      <= (ramp == 8'd0) ? 8'd0 : ramp - 8'd1;
                    end
                end else if (ramp == 8'd0) begin
                    ramp_down <= 1'b0;
                    ramp      <= (duty == 8'd0) ? 8'd0 : 8'd1;
                end else begin
                    ramp <= ramp - 8'd1;
                end
            end
        end
    end

    assign duty_next = breathe ? ramp : duty;
`else
    assign breathe   = 1'b0;
    assign duty_next = duty;
`endif

    // NOTE: all state below uses non-blocking assignment so every process sees pre-edge values,
    // which is what makes a write coinciding with frame leave the old value in the shadow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc       <= '0;
            pwm_cnt     <= 8'd0;
            pat_sh      <= '0;
            duty_sh     <= 8'hFF;
            mask_sh     <= '0;
            blink_cnt   <= 16'd0;
            blink_phase <= 1'b0;
            led_out     <= '0;
        end else begin
            presc <= step ? '0 : presc + 1'b1;
            if (step)
                pwm_cnt <= pwm_cnt + 8'd1;

            if (frame) begin
                pat_sh  <= led_pattern;
                duty_sh <= duty_next;
                mask_sh <= blink_mask;
                if (blink_cnt == half_eff - 16'd1) begin
                    blink_cnt   <= 16'd0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 16'd1;
                end
            end
            // A BLINK_HALF write restarts the half-period count but leaves the phase alone.
            if (wr && address == ADDR_HALF)
                blink_cnt <= 16'd0;

            led_out <= enable ? (pat_sh & ~(mask_sh & {WIDTH{blink_phase}}) & {WIDTH{on}}) : '0;
        end
    end

    always_comb begin
        readdata = '0;
        case (addr_e'(address))
            ADDR_CTRL: begin
                readdata[7:0] = duty;
                readdata[8]   = enable;
                readdata[9]   = breathe;
            end
            ADDR_MASK: readdata[WIDTH-1:0] = blink_mask;
            ADDR_HALF: readdata[15:0] = blink_half;
            ADDR_STATUS: begin
                readdata[WIDTH-1:0] = led_out;
                readdata[WIDTH]     = blink_phase;
            end
        endcase
    end
endmodule

// File: tb/tb_led_red_pwm_driver.sv
// Randomized self-checking bench for led_red_pwm_driver (default build, PRESC_DIV=2 so a frame is 512 cycles).
// A frame-time reference model derived from cycle arithmetic predicts led_out and every register read.
module tb_led_red_pwm_driver;
    localparam int W     = 18;
    localparam int P     = 2;
    localparam int FRAME = 256 * P;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [W-1:0]  led_pattern = '0;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [W-1:0]  led_out;

    int n_checks = 0;
    int n_fail   = 0;

    led_red_pwm_driver #(.WIDTH(W), .PRESC_DIV(P), .BLINK_RST(500)) dut (
        .clk(clk), .reset_n(reset_n), .led_pattern(led_pattern), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .led_out(led_out)
    );

    always #5 clk = ~clk;

    // Reference model: time is m_t cycles since reset release; position within the frame is m_t % FRAME.
    int           m_t;
    logic [7:0]   m_duty;
    logic         m_en;
    logic [W-1:0] m_mask;
    logic [15:0]  m_half;
    logic [W-1:0] s_pat;
    logic [7:0]   s_duty;
    logic [W-1:0] s_mask;
    logic         m_phase;
    int           m_frames_in_half;
    logic [W-1:0] m_led;
    int           mpos;
    int           mstep;
    int           mhalf;
    logic         mlit;
    logic [W-1:0] mnext;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_t = 0; m_duty = 8'hFF; m_en = 1'b1; m_mask = '0; m_half = 16'd500;
            s_pat = '0; s_duty = 8'hFF; s_mask = '0;
            m_phase = 1'b0; m_frames_in_half = 0; m_led = '0;
        end else begin
            mpos  = m_t % FRAME;
            mstep = mpos / P;
            mlit  = (s_duty == 8'hFF) || (mstep < int'(s_duty));
            mnext = (m_en && mlit) ? (s_pat & ~(m_phase ? s_mask : '0)) : '0;
            if (mpos == FRAME - 1) begin
                s_pat = led_pattern; s_duty = m_duty; s_mask = m_mask;
                mhalf = (m_half == 16'd0) ? 1 : int'(m_half);
                m_frames_in_half = m_frames_in_half + 1;
                if (m_frames_in_half == mhalf) begin
                    m_frames_in_half = 0;
                    m_phase = !m_phase;
                end
            end
            if (chipselect && !write_n) begin
                case (address)
                    2'd0: begin m_duty = writedata[7:0]; m_en = writedata[8]; end
                    2'd1: m_mask = writedata[W-1:0];
                    2'd2: begin m_half = writedata[15:0]; m_frames_in_half = 0; end
                    default: ;
                endcase
            end
            m_led = mnext;
            m_t = m_t + 1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {23'd0, m_en, m_duty};
            2'd1:    return {14'd0, m_mask};
            2'd2:    return {16'd0, m_half};
            default: return {13'd0, m_phase, m_led};
        endcase
    endfunction

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic run_model(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_checks++;
            if (led_out !== m_led) begin
                n_fail++;
                $display("FAIL %s led_out cycle %0d: got %h want %h", tag, i, led_out, m_led);
            end
        end
    endtask

    task automatic seek_pos(input int pos, input string tag);
        bit found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (m_t % FRAME == pos) found = 1;
            else @(negedge clk);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s seek: frame position %0d not reached, got %0d", tag, pos, m_t % FRAME);
        end
    endtask

    task automatic test_reset();
        logic [W-1:0] want;
        reset_n = 1'b0; led_pattern = 18'h3FFFF; address = 2'd3;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 513; k++) begin
            @(negedge clk);
            want = (k <= 512) ? 18'h0 : 18'h3FFFF;
            n_checks++;
            if (led_out !== want) begin
                n_fail++;
                $display("FAIL reset_first_frame edge %0d: got %h want %h", k, led_out, want);
            end
        end
        #1;
        n_checks++;
        if (readdata !== 32'h0003FFFF) begin
            n_fail++;
            $display("FAIL reset_status: got %h want %h", readdata, 32'h0003FFFF);
        end
        address = 2'd0; #1;
        n_checks++;
        if (readdata !== 32'h000001FF) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h want %h", readdata, 32'h000001FF);
        end
        address = 2'd2; #1;
        n_checks++;
        if (readdata !== 32'd500) begin
            n_fail++;
            $display("FAIL reset_half: got %h want %h", readdata, 32'd500);
        end
    endtask

    task automatic test_pwm_duty();
        logic [31:0] ctrl_vals [3] = '{32'h180, 32'h100, 32'h1FF};
        int          want_on   [3] = '{256, 0, 512};
        int          ones;
        led_pattern = 18'h00001;
        for (int v = 0; v < 3; v++) begin
            do_write(2'd0, ctrl_vals[v]);
            run_model(2 * FRAME, "pwm_settle");
            ones = 0;
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                ones += int'(led_out[0]);
                n_checks++;
                if (led_out !== m_led) begin
                    n_fail++;
                    $display("FAIL pwm_model cycle %0d: got %h want %h", i, led_out, m_led);
                end
            end
            n_checks++;
            if (ones != want_on[v]) begin
                n_fail++;
                $display("FAIL pwm_on_count ctrl=%h: got %0d want %0d", ctrl_vals[v], ones, want_on[v]);
            end
        end
    endtask

    task automatic test_blink();
        int   ones0 = 0;
        int   ones1 = 0;
        int   edges = 0;
        logic prev;
        led_pattern = 18'h00003;
        do_write(2'd1, 32'h1);
        do_write(2'd2, 32'h2);
        do_write(2'd0, 32'h1FF);
        address = 2'd3;
        run_model(2 * FRAME, "blink_settle");
        prev = led_out[0];
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            ones0 += int'(led_out[0]);
            ones1 += int'(led_out[1]);
            if (led_out[0] != prev) edges++;
            prev = led_out[0];
            #1;
            n_checks++;
            if (readdata !== exp_rd(2'd3)) begin
                n_fail++;
                $display("FAIL blink_status cycle %0d: got %h want %h", i, readdata, exp_rd(2'd3));
            end
        end
        n_checks++;
        if (ones0 != 2 * FRAME || edges != 2) begin
            n_fail++;
            $display("FAIL blink_bit0: on %0d edges %0d, want on %0d edges 2", ones0, edges, 2 * FRAME);
        end
        n_checks++;
        if (ones1 != 4 * FRAME) begin
            n_fail++;
            $display("FAIL blink_bit1_steady: got %0d want %0d", ones1, 4 * FRAME);
        end
        do_write(2'd1, 32'h0);
    endtask

    task automatic test_midframe_pattern();
        logic [W-1:0] pat_a = W'($urandom) | 18'h1;
        logic [W-1:0] pat_b = ~pat_a;
        logic [W-1:0] want;
        led_pattern = pat_a;
        do_write(2'd0, 32'h1FF);
        run_model(3 * FRAME, "mid_settle");
        seek_pos(100, "mid");
        led_pattern = pat_b;
        for (int k = 1; k <= 413; k++) begin
            @(negedge clk);
            want = (k <= 412) ? pat_a : pat_b;
            n_checks++;
            if (led_out !== want) begin
                n_fail++;
                $display("FAIL midframe_pattern edge %0d: got %h want %h", k, led_out, want);
            end
        end
    endtask

    task automatic test_enable_off();
        logic [W-1:0] lit_val = led_out;
        do_write(2'd0, 32'h0FF);
        n_checks++;
        if (led_out !== lit_val) begin
            n_fail++;
            $display("FAIL enable_off_write_edge: got %h want %h", led_out, lit_val);
        end
        @(negedge clk);
        n_checks++;
        if (led_out !== '0) begin
            n_fail++;
            $display("FAIL enable_off_next_edge: got %h want 0", led_out);
        end
        run_model(FRAME + 37, "enable_off");
        do_write(2'd0, 32'h1FF);
        run_model(2 * FRAME, "enable_back_on");
    endtask

    task automatic test_random();
        logic [31:0] wd;
        logic [1:0]  a;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: begin wd = $urandom; wd[8] = ($urandom_range(0, 3) != 0); do_write(2'd0, wd); end
                1: do_write(2'd1, $urandom);
                2: do_write(2'd2, 32'($urandom_range(0, 3)));
                3: do_write(2'd3, $urandom);
                default: led_pattern = W'($urandom);
            endcase
            for (int i = $urandom_range(50, 700); i > 0; i--) begin
                @(negedge clk);
                n_checks++;
                if (led_out !== m_led) begin
                    n_fail++;
                    $display("FAIL random_led iter %0d: got %h want %h", it, led_out, m_led);
                end
                a = 2'($urandom_range(0, 3));
                address = a;
                #1;
                n_checks++;
                if (readdata !== exp_rd(a)) begin
                    n_fail++;
                    $display("FAIL random_read addr %0d iter %0d: got %h want %h", a, it, readdata, exp_rd(a));
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [1:0]  addrs [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [31:0] wants [4] = '{32'h1FF, 32'h0, 32'd500, 32'h0};
        led_pattern = 18'h3FFFF;
        do_write(2'd1, 32'h0);
        do_write(2'd0, 32'h1FF);
        run_model(2 * FRAME, "rst_settle");
        seek_pos(200, "rst");
        n_checks++;
        if (led_out !== 18'h3FFFF) begin
            n_fail++;
            $display("FAIL reset_mid_lit: got %h want %h", led_out, 18'h3FFFF);
        end
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (led_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got %h want 0", led_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            address = addrs[i];
            #1;
            n_checks++;
            if (readdata !== wants[i]) begin
                n_fail++;
                $display("FAIL reset_mid_read addr %0d: got %h want %h", addrs[i], readdata, wants[i]);
            end
        end
        run_model(FRAME + 50, "after_reset");
    endtask

    initial begin
        test_reset();
        test_pwm_duty();
        test_blink();
        test_midframe_pattern();
        test_enable_off();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
